rs_cmd_debounce: RTL and testbench
==================================

// Module: rs_cmd_debounce
// PURPOSE
//   Command front-end for the rs_ff set/reset flip-flop. Takes two raw, asynchronous,
//   bouncy push-button levels (set, reset), synchronises and debounces each, and emits
//   single-cycle s / r command pulses that drive the flip-flop's s and r inputs directly.
//   Guarantees s and r are never high together, so the flip-flop never enters its
//   undefined s=r=1 case.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive cycles a synchronised input must differ from its
//                        debounced state before the state flips; legal 1..2**CNT_W
//   CNT_W            3  width of each debounce counter
// PORTS
//   clk       input   1  system clock, all state on rising edge
//   rst_n     input   1  asynchronous active-low reset
//   set_btn   input   1  raw set request level, asynchronous to clk, may bounce
//   rst_btn   input   1  raw reset request level, asynchronous to clk, may bounce
//   s         output  1  set command pulse to rs_ff.s, one cycle wide
//   r         output  1  reset command pulse to rs_ff.r, one cycle wide
//   set_lvl   output  1  debounced level of set_btn
//   rst_lvl   output  1  debounced level of rst_btn
//   conflict  output  1  one-cycle flag: both channels qualified on the same edge
// BEHAVIOUR
//   - Reset (rst_n=0, async): sync flops, counters, set_lvl, rst_lvl, s, r, conflict all 0.
//     Release is taken on the first rising clk with rst_n=1.
//   - Per channel: 2-flop synchroniser (sync1, sync2). Debounced state lvl and counter cnt:
//       sync2 == lvl                       -> cnt <= 0
//       sync2 != lvl, cnt <  DEBOUNCE_CYCLES-1 -> cnt <= cnt+1
//       sync2 != lvl, cnt == DEBOUNCE_CYCLES-1 -> lvl <= sync2, cnt <= 0
//     A single cycle of sync2 == lvl restarts the count (bounce rejection).
//   - Qualify event: lvl going 0->1 on an edge (rising only; 1->0 produces no pulse).
//   - Outputs registered, updated on the same edge as lvl:
//       set qualify only   -> s=1, r=0, conflict=0
//       reset qualify only -> s=0, r=1, conflict=0
//       both same edge     -> s=0, r=1, conflict=1 (reset wins)
//       neither            -> s=0, r=0, conflict=0
//     s, r, conflict are high for exactly one cycle per qualify event.
//   - Latency: raw input changes between edges; counting that next edge as edge 1,
//     sync2 updates at edge 2 and lvl/pulse update at edge DEBOUNCE_CYCLES+2
//     (edge 6 at default). The release of a button is debounced with the same latency.
//   - Holding a button produces one pulse only; a new pulse needs a debounced release
//     then a debounced press.
//   - Channels are independent: one held does not block the other's pulse (only the
//     same-edge collision is arbitrated).
//   - Reset mid-count discards the count; a button held through reset is treated as a
//     new press and pulses DEBOUNCE_CYCLES+2 edges after rst_n rises.
//   - Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
// TESTING
//   1. set_btn 0->1 and held, default params -> s high exactly during the cycle after
//      edge 6, set_lvl=1 from edge 6, r=0, conflict=0 throughout.
//   2. set_btn bounces 1,0,1,1,0 (one cycle each) then steady 1 -> no s pulse during the
//      bounce; exactly one s pulse 6 edges after the final steady 1 begins.
//   3. set_btn and rst_btn rise together -> r=1, conflict=1 for one cycle at edge 6;
//      s stays 0; set_lvl=rst_lvl=1.
//   4. rst_btn held 20 cycles then released -> one r pulse at edge 6; rst_lvl returns to
//      0 six edges after release with no pulse; pressing again gives a second r pulse.
//   5. set_btn held; rst_n pulsed low at edge 3 (mid-count) -> all outputs 0 immediately;
//      after rst_n rises, s pulses at the 6th edge after release.
//   6. DEBOUNCE_CYCLES=1 -> s pulse at edge 3; a 1-cycle glitch on rst_btn produces a
//      2-cycle-latent r pulse (no filtering), confirming the parameter lower bound.

Source files
------------

// File: rtl/rs_cmd_debounce.sv
// rs_cmd_debounce: sync + debounce two bouncy buttons into exclusive s/r pulses for rs_ff.
// Ports: clk, rst_n (async low); set_btn, rst_btn raw in; s, r, set_lvl, rst_lvl, conflict out.
module rs_cmd_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_btn,
   input  logic rst_btn,
   output logic s,
   output logic r,
   output logic set_lvl,
   output logic rst_lvl,
   output logic conflict
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // channel 0 = set, channel 1 = reset
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_lvl;
   logic [CNT_W-1:0] r_cnt [2];
   logic             r_s;
   logic             r_r;
   logic             r_conflict;

   logic [1:0]       w_diff;
   logic [1:0]       w_hit;
   logic [1:0]       w_rise;

   always_comb begin
      w_diff = '0;
      w_hit  = '0;
      w_rise = '0;
      for (int i = 0; i < 2; i++) begin
         w_diff[i] = r_sync2[i] ^ r_lvl[i];
         w_hit[i]  = w_diff[i] && (r_cnt[i] == LP_LAST);
         // lvl flips this edge and the new value is 1
         w_rise[i] = w_hit[i] & r_sync2[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_lvl      <= '0;
         r_cnt[0]   <= '0;
         r_cnt[1]   <= '0;
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_conflict <= 1'b0;
      end else begin
         r_sync1 <= {rst_btn, set_btn};
         r_sync2 <= r_sync1;
         for (int i = 0; i < 2; i++) begin
            if (!w_diff[i]) begin
               r_cnt[i] <= '0;
            end else if (w_hit[i]) begin
               r_cnt[i] <= '0;
               r_lvl[i] <= r_sync2[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
         // reset wins a same-edge collision so s and r are never both high
         r_s        <= w_rise[0] & ~w_rise[1];
         r_r        <= w_rise[1];
         r_conflict <= w_rise[0] & w_rise[1];
      end
   end

   assign s        = r_s;
   assign r        = r_r;
   assign conflict = r_conflict;
   assign set_lvl  = r_lvl[0];
   assign rst_lvl  = r_lvl[1];

endmodule

// File: tb/tb_rs_cmd_debounce.sv
// tb_rs_cmd_debounce: checks rs_cmd_debounce at DEBOUNCE_CYCLES=4 and =1 side by side.
// Table vectors, hand sequences and random stimulus against a window-based reference.
module tb_rs_cmd_debounce;

   logic       clk;
   logic       rst_n;
   logic       set_btn;
   logic       rst_btn;
   logic [1:0] d_s;
   logic [1:0] d_r;
   logic [1:0] d_sl;
   logic [1:0] d_rl;
   logic [1:0] d_c;

   int checks;
   int failures;

   rs_cmd_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .rst_btn(rst_btn),
      .s(d_s[0]), .r(d_r[0]), .set_lvl(d_sl[0]), .rst_lvl(d_rl[0]),
      .conflict(d_c[0])
   );

   rs_cmd_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .rst_btn(rst_btn),
      .s(d_s[1]), .r(d_r[1]), .set_lvl(d_sl[1]), .rst_lvl(d_rl[1]),
      .conflict(d_c[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Debounced level flips once the last D sync2 samples all disagree with it.
   // sync2 seen at edge n is the raw level sampled at edge n-2 (0 before that).
   logic raw_s[$];
   logic raw_r[$];
   logic s2_s[$];
   logic s2_r[$];
   logic m_lvl_s[2];
   logic m_lvl_r[2];
   logic e_s[2];
   logic e_r[2];
   logic e_c[2];

   function automatic int dc_of(int k);
      return (k == 0) ? 4 : 1;
   endfunction

   function automatic bit all_differ(bit ch, int d, logic lvl);
      int n;
      n = ch ? s2_r.size() : s2_s.size();
      if (n < d) return 1'b0;
      for (int i = 0; i < d; i++) begin
         if ((ch ? s2_r[n-1-i] : s2_s[n-1-i]) == lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_clear();
      raw_s.delete();
      raw_r.delete();
      s2_s.delete();
      s2_r.delete();
      for (int k = 0; k < 2; k++) begin
         m_lvl_s[k] = 1'b0;
         m_lvl_r[k] = 1'b0;
         e_s[k]     = 1'b0;
         e_r[k]     = 1'b0;
         e_c[k]     = 1'b0;
      end
   endtask

   task automatic model_step();
      int  n;
      logic rs;
      logic rr;
      raw_s.push_back(set_btn);
      raw_r.push_back(rst_btn);
      n = raw_s.size();
      s2_s.push_back((n >= 3) ? raw_s[n-3] : 1'b0);
      s2_r.push_back((n >= 3) ? raw_r[n-3] : 1'b0);
      for (int k = 0; k < 2; k++) begin
         rs = 1'b0;
         rr = 1'b0;
         if (all_differ(1'b0, dc_of(k), m_lvl_s[k])) begin
            rs         = ~m_lvl_s[k];
            m_lvl_s[k] = ~m_lvl_s[k];
         end
         if (all_differ(1'b1, dc_of(k), m_lvl_r[k])) begin
            rr         = ~m_lvl_r[k];
            m_lvl_r[k] = ~m_lvl_r[k];
         end
         e_s[k] = rs & ~rr;
         e_r[k] = rr;
         e_c[k] = rs & rr;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic chk_model();
      int n;
      n = raw_s.size();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d_s_e%0d", k, n), int'(d_s[k]), int'(e_s[k]));
         chk($sformatf("d%0d_r_e%0d", k, n), int'(d_r[k]), int'(e_r[k]));
         chk($sformatf("d%0d_c_e%0d", k, n), int'(d_c[k]), int'(e_c[k]));
         chk($sformatf("d%0d_sl_e%0d", k, n), int'(d_sl[k]), int'(m_lvl_s[k]));
         chk($sformatf("d%0d_rl_e%0d", k, n), int'(d_rl[k]), int'(m_lvl_r[k]));
         chk($sformatf("d%0d_excl_e%0d", k, n), int'(d_s[k] & d_r[k]), 0);
      end
   endtask

   // drive between edges, model the edge, sample 1 time unit after it
   task automatic tick(input logic sb, input logic rb);
      @(negedge clk);
      set_btn = sb;
      rst_btn = rb;
      @(posedge clk);
      model_step();
      #1;
      chk_model();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_clear();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst%0d_s", k), int'(d_s[k]), 0);
         chk($sformatf("rst%0d_r", k), int'(d_r[k]), 0);
         chk($sformatf("rst%0d_c", k), int'(d_c[k]), 0);
         chk($sformatf("rst%0d_sl", k), int'(d_sl[k]), 0);
         chk($sformatf("rst%0d_rl", k), int'(d_rl[k]), 0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- vector table (DEBOUNCE_CYCLES=4) ----------------
   typedef struct {
      logic sb;
      logic rb;
      logic es;
      logic er;
      logic ec;
      logic esl;
      logic erl;
   } vec_t;

   vec_t tbl[20];
   int   pc;
   int   pidx;
   int   pc2;
   int   pidx2;

   initial begin
      checks   = 0;
      failures = 0;
      set_btn  = 1'b0;
      rst_btn  = 1'b0;
      rst_n    = 1'b1;
      model_clear();

      // both pressed, release, then set press
      for (int i = 0; i < 5; i++) tbl[i] = '{1, 1, 0, 0, 0, 0, 0};
      tbl[5] = '{1, 1, 0, 1, 1, 1, 1};
      tbl[6] = '{1, 1, 0, 0, 0, 1, 1};
      for (int i = 7; i < 12; i++) tbl[i] = '{0, 0, 0, 0, 0, 1, 1};
      tbl[12] = '{0, 0, 0, 0, 0, 0, 0};
      for (int i = 13; i < 18; i++) tbl[i] = '{1, 0, 0, 0, 0, 0, 0};
      tbl[18] = '{1, 0, 1, 0, 0, 1, 0};
      tbl[19] = '{1, 0, 0, 0, 0, 1, 0};

      #2;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         tick(tbl[i].sb, tbl[i].rb);
         chk($sformatf("tbl%0d_s", i), int'(d_s[0]), int'(tbl[i].es));
         chk($sformatf("tbl%0d_r", i), int'(d_r[0]), int'(tbl[i].er));
         chk($sformatf("tbl%0d_c", i), int'(d_c[0]), int'(tbl[i].ec));
         chk($sformatf("tbl%0d_sl", i), int'(d_sl[0]), int'(tbl[i].esl));
         chk($sformatf("tbl%0d_rl", i), int'(d_rl[0]), int'(tbl[i].erl));
      end

      // press and hold set: s at edge 6 (DC=4), edge 3 (DC=1)
      set_btn = 1'b0;
      rst_btn = 1'b0;
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         tick(1'b1, 1'b0);
         chk($sformatf("t1_s4_e%0d", i), int'(d_s[0]), int'(i == 6));
         chk($sformatf("t1_sl4_e%0d", i), int'(d_sl[0]), int'(i >= 6));
         chk($sformatf("t1_s1_e%0d", i), int'(d_s[1]), int'(i == 3));
      end

      // bounce 1,0,1,1,0 then steady 1
      set_btn = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
      pc   = 0;
      pidx = -1;
      for (int i = 0; i < 14; i++) begin
         tick((i == 1 || i == 4) ? 1'b0 : 1'b1, 1'b0);
         if (d_s[0]) begin
            pc++;
            pidx = i;
         end
      end
      chk("t2_pulses", pc, 1);
      chk("t2_pulse_at", pidx, 10);

      // reset held 20, released 10, pressed again
      set_btn = 1'b0;
      do_reset();
      pc    = 0;
      pidx  = -1;
      pidx2 = -1;
      for (int i = 0; i < 40; i++) begin
         tick(1'b0, (i < 20 || i >= 30) ? 1'b1 : 1'b0);
         if (d_r[0]) begin
            pc++;
            if (pidx < 0) pidx = i;
            else pidx2 = i;
         end
         if (i == 24) chk("t4_rl_hold", int'(d_rl[0]), 1);
         if (i == 25) chk("t4_rl_drop", int'(d_rl[0]), 0);
      end
      chk("t4_pulses", pc, 2);
      chk("t4_first", pidx, 5);
      chk("t4_second", pidx2, 35);

      // reset mid-count with set held through it
      rst_btn = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
      chk("t5_pre_s1", int'(d_s[1]), 1);
      do_reset();
      for (int i = 1; i <= 7; i++) begin
         tick(1'b1, 1'b0);
         chk($sformatf("t5_s4_e%0d", i), int'(d_s[0]), int'(i == 6));
      end

      // one-cycle glitch on rst_btn: filtered at DC=4, passed at DC=1
      set_btn = 1'b0;
      do_reset();
      pc2 = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, (i == 3) ? 1'b1 : 1'b0);
         if (i == 5) chk("t6_r1_pulse", int'(d_r[1]), 1);
         if (d_r[0]) pc2++;
      end
      chk("t6_r4_none", pc2, 0);

      // random stimulus with slow toggling so presses survive debouncing
      set_btn = 1'b0;
      rst_btn = 1'b0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic sb;
         logic rb;
         sb = set_btn;
         rb = rst_btn;
         if ($urandom_range(5) == 0) sb = ~sb;
         if ($urandom_range(5) == 0) rb = ~rb;
         tick(sb, rb);
         if (i % 700 == 699) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
